// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared constants for the data-memory/UART port arbiter
package dmem_arbiter_pkg;
  localparam int DMEM_WORD_LEN = 32;
  localparam logic [31:0] DMEM_UART_ADDR = 32'h1000_0000;
  localparam logic OWNER_C = 1'b0;
  localparam logic OWNER_L = 1'b1;
  localparam logic [DMEM_WORD_LEN-1:0] UART_MASK = ~DMEM_WORD_LEN'(7);
  localparam logic ARB_RR = 1'b0;
  localparam logic ARB_LOCKED = 1'b1;
endpackage

// File: rtl/dmem_rr_arb.sv
// dmem_rr_arb: 2-way round-robin grant with a loader-exclusive lock
module dmem_rr_arb
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic c_req,
  input  logic l_req,
  input  logic l_lock,
  output logic c_gnt,
  output logic l_gnt,
  output logic owner
);
  logic state, last_owner, locked;
  // dropping l_lock releases the lock in the same cycle, so that cycle is plain RR
  assign locked = (state == ARB_LOCKED) && l_lock;
  assign c_gnt = !rst && !locked && c_req && (!l_req || last_owner == OWNER_L);
  assign l_gnt = !rst && l_req && (locked || !c_req || last_owner == OWNER_C);
  assign owner = rst ? OWNER_L : l_gnt ? OWNER_L : c_gnt ? OWNER_C : last_owner;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_RR;
      last_owner <= OWNER_L;
    end else begin
      last_owner <= owner;
      state <= (l_gnt && l_lock) ? ARB_LOCKED : l_lock ? state : ARB_RR;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory/UART port between the core and the loader
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WORD_LEN = DMEM_WORD_LEN,
  parameter logic [WORD_LEN-1:0] UART_ADDR = WORD_LEN'(DMEM_UART_ADDR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic [WORD_LEN-1:0] c_addr,
  input  logic                c_wen,
  input  logic [WORD_LEN-1:0] c_wdata,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [WORD_LEN-1:0] c_rdata,
  input  logic                l_req,
  input  logic [WORD_LEN-1:0] l_addr,
  input  logic                l_wen,
  input  logic [WORD_LEN-1:0] l_wdata,
  output logic                l_gnt,
  output logic                l_rvalid,
  output logic [WORD_LEN-1:0] l_rdata,
  input  logic                l_lock,
  output logic [WORD_LEN-1:0] m_addr,
  output logic [WORD_LEN-1:0] m_wdata,
  output logic                m_wen,
  output logic                u_wen,
  input  logic [WORD_LEN-1:0] m_rdata,
  input  logic [WORD_LEN-1:0] u_rdata,
  output logic                owner
);
  logic any_gnt, sel_wen, is_uart, rd_pend, rd_owner, rd_uart;
  dmem_rr_arb u_arb (
    .clk(clk), .rst(rst), .c_req(c_req), .l_req(l_req), .l_lock(l_lock),
    .c_gnt(c_gnt), .l_gnt(l_gnt), .owner(owner)
  );
  assign any_gnt = c_gnt | l_gnt;
  assign m_addr = l_gnt ? l_addr : c_addr;
  assign m_wdata = l_gnt ? l_wdata : c_wdata;
  assign sel_wen = l_gnt ? l_wen : c_wen;
  assign is_uart = (m_addr & ~WORD_LEN'(7)) == UART_ADDR;
  assign m_wen = any_gnt && sel_wen && !is_uart;
  assign u_wen = any_gnt && sel_wen && is_uart;
  // read data returns one cycle later; remember who asked and which target answers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_owner <= OWNER_C;
      rd_uart <= 1'b0;
    end else begin
      rd_pend <= any_gnt && !sel_wen;
      rd_owner <= l_gnt;
      rd_uart <= is_uart;
    end
  end
  assign c_rvalid = !rst && rd_pend && rd_owner == OWNER_C;
  assign l_rvalid = !rst && rd_pend && rd_owner == OWNER_L;
  assign c_rdata = rd_uart ? u_rdata : m_rdata;
  assign l_rdata = rd_uart ? u_rdata : m_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, corner sequences and random traffic against a reference model
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;
  localparam logic [31:0] UA = DMEM_UART_ADDR;
  logic clk = 1'b0;
  logic rst = 1'b1, c_req = 1'b0, c_wen = 1'b0, l_req = 1'b0, l_wen = 1'b0, l_lock = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0, m_rdata = '0, u_rdata = '0;
  logic c_gnt, l_gnt, c_rvalid, l_rvalid, m_wen, u_wen, owner;
  logic [31:0] c_rdata, l_rdata, m_addr, m_wdata;
  int compared = 0, mismatched = 0;
  bit mdl_last = 1'b1, mdl_locked = 1'b0, pend = 1'b0, pend_owner = 1'b0, pend_uart = 1'b0;
  int last_win = -1;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_wen(c_wen), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_wen(l_wen), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_lock(l_lock),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .u_wen(u_wen),
    .m_rdata(m_rdata), .u_rdata(u_rdata), .owner(owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks every output of the current cycle against the model, then advances one clock.
  task automatic step();
    int win;
    bit is_u, ew, eo;
    logic [31:0] ea, ed;
    #3;
    if (rst) win = -1;
    else if (mdl_locked && l_lock) win = l_req ? 1 : -1;
    else if (c_req && l_req) win = mdl_last ? 0 : 1;
    else win = c_req ? 0 : (l_req ? 1 : -1);
    ea = (win == 1) ? l_addr : c_addr;
    ed = (win == 1) ? l_wdata : c_wdata;
    ew = (win == 1) ? l_wen : c_wen;
    is_u = (ea >> 3) == (UA >> 3);
    eo = rst ? 1'b1 : (win < 0 ? mdl_last : (win == 1));
    chk("c_gnt", {31'b0, c_gnt}, {31'b0, win == 0});
    chk("l_gnt", {31'b0, l_gnt}, {31'b0, win == 1});
    chk("m_addr", m_addr, ea);
    chk("m_wdata", m_wdata, ed);
    chk("m_wen", {31'b0, m_wen}, {31'b0, win >= 0 && ew && !is_u});
    chk("u_wen", {31'b0, u_wen}, {31'b0, win >= 0 && ew && is_u});
    chk("owner", {31'b0, owner}, {31'b0, eo});
    chk("c_rvalid", {31'b0, c_rvalid}, {31'b0, !rst && pend && !pend_owner});
    chk("l_rvalid", {31'b0, l_rvalid}, {31'b0, !rst && pend && pend_owner});
    if (!rst && pend)
      chk(pend_owner ? "l_rdata" : "c_rdata", pend_owner ? l_rdata : c_rdata, pend_uart ? u_rdata : m_rdata);
    if (rst) begin
      mdl_last = 1'b1;
      mdl_locked = 1'b0;
      pend = 1'b0;
    end else begin
      pend = win >= 0 && !ew;
      pend_owner = win == 1;
      pend_uart = is_u;
      if (win >= 0) mdl_last = (win == 1);
      if (win == 1 && l_lock) mdl_locked = 1'b1;
      else if (!l_lock) mdl_locked = 1'b0;
    end
    last_win = win;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(3) == 0) ? UA + 32'($urandom_range(7)) : ($urandom & 32'h0000_0ffc);
  endfunction

  typedef struct {
    logic rst, c_req, c_wen, l_req, l_wen, l_lock;
    logic [31:0] c_addr, l_addr, wdata;
    logic e_cg, e_lg, e_mw, e_uw, e_own;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{1, 1, 0, 1, 1, 0, 32'h100, 32'h10, 32'h1, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 1, 0, 0, 0, 0, 32'h100, 32'h10, 32'h2, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 1, 1, 0, 32'h200, 32'h10, 32'h3, 0, 1, 1, 0, 1};
    tbl[3] = '{0, 1, 0, 1, 1, 0, 32'h200, 32'h14, 32'h4, 1, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 1, 1, 0, 32'h300, 32'h14, 32'h5, 0, 1, 1, 0, 1};
    tbl[5] = '{0, 0, 0, 1, 1, 0, 32'h300, UA + 4, 32'h41, 0, 1, 0, 1, 1};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 32'h300, UA + 4, 32'h6, 0, 0, 0, 0, 1};
    #1;
    step();
    foreach (tbl[i]) begin
      rst = tbl[i].rst; c_req = tbl[i].c_req; c_wen = tbl[i].c_wen; c_addr = tbl[i].c_addr;
      l_req = tbl[i].l_req; l_wen = tbl[i].l_wen; l_addr = tbl[i].l_addr; l_lock = tbl[i].l_lock;
      c_wdata = tbl[i].wdata; l_wdata = ~tbl[i].wdata; m_rdata = $urandom; u_rdata = $urandom;
      #1;
      chk($sformatf("tbl%0d_c_gnt", i), {31'b0, c_gnt}, {31'b0, tbl[i].e_cg});
      chk($sformatf("tbl%0d_l_gnt", i), {31'b0, l_gnt}, {31'b0, tbl[i].e_lg});
      chk($sformatf("tbl%0d_m_wen", i), {31'b0, m_wen}, {31'b0, tbl[i].e_mw});
      chk($sformatf("tbl%0d_u_wen", i), {31'b0, u_wen}, {31'b0, tbl[i].e_uw});
      chk($sformatf("tbl%0d_owner", i), {31'b0, owner}, {31'b0, tbl[i].e_own});
      step();
    end
    // core read returning DEADBEEF
    rst = 1; step(); rst = 0;
    c_req = 1; c_wen = 0; c_addr = 32'h100; l_req = 0; l_lock = 0;
    step();
    c_req = 0; m_rdata = 32'hDEADBEEF; u_rdata = 32'h0;
    #1;
    chk("seq_c_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("seq_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("seq_l_rvalid", {31'b0, l_rvalid}, 32'd0);
    step();
    // loader UART read
    l_req = 1; l_wen = 0; l_addr = UA;
    step();
    l_req = 0; u_rdata = 32'h5A; m_rdata = 32'h11;
    #1;
    chk("seq_uart_rdata", l_rdata, 32'h5A);
    step();
    // lock: C wins first contention, then L holds the port for 5 writes
    begin
      int lgrants = 0;
      c_req = 1; c_wen = 1; c_addr = 32'h80; l_req = 1; l_wen = 1; l_lock = 1; l_addr = 32'h40;
      for (int k = 0; k < 12 && lgrants < 5; k++) begin
        #1;
        if (lgrants > 0) chk("lock_c_held", {31'b0, c_gnt}, 32'd0);
        step();
        if (last_win == 0) c_addr = 32'h84;
        if (last_win == 1) begin
          lgrants++;
          l_addr = 32'h40 + 32'(4 * lgrants);
        end
      end
      chk("lock_grants", 32'(lgrants), 32'd5);
      l_lock = 0; l_req = 0;
      #1;
      chk("unlock_c_gnt", {31'b0, c_gnt}, 32'd1);
      step();
    end
    // read granted right before reset
    c_req = 1; c_wen = 0; c_addr = 32'h200; l_lock = 1; l_req = 1; l_wen = 0; l_addr = 32'h300;
    step();
    rst = 1; c_req = 0; l_req = 0;
    step();
    rst = 0; l_lock = 0; c_req = 1; l_req = 1;
    #1;
    chk("post_rst_c_first", {31'b0, c_gnt}, 32'd1);
    step();
    c_req = 0; l_req = 0;
    step();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (rst || !c_req || last_win == 0) begin
        c_req = $urandom_range(2) != 0; c_addr = rand_addr(); c_wen = $urandom_range(1); c_wdata = $urandom;
      end
      if (rst || !l_req || last_win == 1) begin
        l_req = $urandom_range(2) != 0; l_addr = rand_addr(); l_wen = $urandom_range(1); l_wdata = $urandom;
      end
      rst = $urandom_range(99) == 0;
      if ($urandom_range(7) == 0) l_lock = ~l_lock;
      m_rdata = $urandom; u_rdata = $urandom;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
